pcs_tx_sched: RTL and testbench

PCS_TX_SCHED -- requirements
Module: pcs_tx_sched

---
 rtl/pcs_pkg.sv | 26 ++
 rtl/pcs_gb_seq_cnt.sv | 43 ++++
 rtl/pcs_tx_sched.sv | 159 +++++++++++++++
 tb/tb_pcs_tx_sched.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pcs_pkg
//  Description : Constants and types shared by the PCS TX and RX paths.
//                Sync headers, idle block type, sequence counter width and
//                the TX block-position state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package pcs_pkg;

   localparam logic [1:0] SYNC_CTRL     = 2'b10;
   localparam logic [1:0] SYNC_DATA     = 2'b01;
   localparam logic [7:0] BLK_TYPE_IDLE = 8'h1E;
   localparam int         SEQ_W         = 6;

   // Position inside a 64-bit block. Two tail states are kept apart so the
   // scheduler knows whether the second word comes from the MAC or is the
   // zero half of an inserted idle block.
   typedef enum logic [1:0] {
      BLK_HEAD      = 2'd0,
      BLK_MAC_TAIL  = 2'd1,
      BLK_IDLE_TAIL = 2'd2
   } blk_state_t;

endpackage : pcs_pkg
`default_nettype wire

// File: rtl/pcs_gb_seq_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : pcs_gb_seq_cnt
//  Description : Free-running gearbox sequence counter, 0..SEQ_MAX, with a
//                pause flag raised while the count sits at SEQ_MAX.
//  Ports       : clk     - rising-edge clock
//                reset   - synchronous active-high reset
//                o_seq   - current sequence value
//                o_pause - high in the gearbox pause cycle (seq == SEQ_MAX)
//  Revision    : 1.0  initial release
// ============================================================================
module pcs_gb_seq_cnt
   import pcs_pkg::*;
#(
   parameter int SEQ_MAX = 32
)
(
   input  logic             clk,
   input  logic             reset,
   output logic [SEQ_W-1:0] o_seq,
   output logic             o_pause
);

   localparam logic [SEQ_W-1:0] c_seq_max = SEQ_W'(SEQ_MAX);
   localparam logic [SEQ_W-1:0] c_seq_one = SEQ_W'(1);

   logic [SEQ_W-1:0] r_seq;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_seq <= '0;
      end else if (r_seq == c_seq_max) begin
         r_seq <= '0;
      end else begin
         r_seq <= r_seq + c_seq_one;
      end
   end

   assign o_seq   = r_seq;
   assign o_pause = (r_seq == c_seq_max);

endmodule : pcs_gb_seq_cnt
`default_nettype wire

// File: rtl/pcs_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : pcs_tx_sched
//  Description : 64b/66b PCS transmit scheduler. Splits each block into two
//                LEN-bit words, inserts idle control blocks when the MAC has
//                nothing to send, substitutes zeros on mid-block starvation,
//                and honours the gearbox pause cycle (seq == SEQ_MAX) in
//                which the external scrambler is not advanced.
//  Ports       : clk, reset              - clock, synchronous active-high reset
//                mac_valid_i/ctrl_i/data_i - MAC word in (ctrl on head only)
//                mac_ready_o             - MAC word accepted when also valid
//                scram_valid_o/data_o    - word to external scrambler
//                scram_i                 - scrambled word (combinational)
//                gb_valid_o/head_o/sync_o/data_o, seq_o - gearbox word out
//                underflow_o             - pulse on mid-block starvation
//  Revision    : 1.0  initial release
// ============================================================================
module pcs_tx_sched
   import pcs_pkg::*;
#(
   parameter int LEN     = 32,
   parameter int SEQ_MAX = 32
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             mac_valid_i,
   input  logic             mac_ctrl_i,
   input  logic [LEN-1:0]   mac_data_i,
   output logic             mac_ready_o,
   output logic             scram_valid_o,
   output logic [LEN-1:0]   scram_data_o,
   input  logic [LEN-1:0]   scram_i,
   output logic             gb_valid_o,
   output logic             gb_head_o,
   output logic [1:0]       gb_sync_o,
   output logic [LEN-1:0]   gb_data_o,
   output logic [SEQ_W-1:0] seq_o,
   output logic             underflow_o
);

   localparam logic [LEN-1:0] c_idle_word = LEN'(BLK_TYPE_IDLE);

   logic [SEQ_W-1:0] w_seq;
   logic             w_pause;

   blk_state_t       r_state;
   blk_state_t       w_state_nxt;
   logic [1:0]       r_sync;
   logic [1:0]       w_sync_nxt;
   logic [LEN-1:0]   w_scram_data;
   logic             w_underflow;
   logic             w_half;

   logic             r_gb_valid;
   logic             r_gb_head;
   logic [LEN-1:0]   r_gb_data;
   logic [SEQ_W-1:0] r_gb_seq;
   logic             r_underflow;

   pcs_gb_seq_cnt #(
      .SEQ_MAX (SEQ_MAX)
   ) u_seq_cnt (
      .clk     (clk),
      .reset   (reset),
      .o_seq   (w_seq),
      .o_pause (w_pause)
   );

   // ------------------------------------------------------------------------
   // Block-position state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= BLK_HEAD;
         r_sync  <= 2'b00;
      end else begin
         r_state <= w_state_nxt;
         r_sync  <= w_sync_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and scrambler word selection. In the pause cycle nothing
   // moves: the block position and latched sync are held so a block may
   // straddle the pause.
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt  = r_state;
      w_sync_nxt   = r_sync;
      w_scram_data = '0;
      w_underflow  = 1'b0;
      if (!w_pause) begin
         case (r_state)
            BLK_HEAD: begin
               if (mac_valid_i) begin
                  w_scram_data = mac_data_i;
                  w_sync_nxt   = mac_ctrl_i ? SYNC_CTRL : SYNC_DATA;
                  w_state_nxt  = BLK_MAC_TAIL;
               end else begin
                  w_scram_data = c_idle_word;
                  w_sync_nxt   = SYNC_CTRL;
                  w_state_nxt  = BLK_IDLE_TAIL;
               end
            end
            BLK_MAC_TAIL: begin
               // Starved second half: finish the block with zeros.
               if (mac_valid_i) begin
                  w_scram_data = mac_data_i;
               end else begin
                  w_underflow = 1'b1;
               end
               w_state_nxt = BLK_HEAD;
            end
            BLK_IDLE_TAIL: begin
               w_state_nxt = BLK_HEAD;
            end
            default: begin
               w_state_nxt = BLK_HEAD;
            end
         endcase
      end
   end

   assign w_half        = (r_state != BLK_HEAD);
   assign mac_ready_o   = !w_pause && (r_state != BLK_IDLE_TAIL);
   assign scram_valid_o = !w_pause;
   assign scram_data_o  = w_scram_data;

   // ------------------------------------------------------------------------
   // Gearbox output stage, one cycle behind the scrambler cycle
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_gb_valid  <= 1'b0;
         r_gb_head   <= 1'b0;
         r_gb_data   <= '0;
         r_gb_seq    <= '0;
         r_underflow <= 1'b0;
      end else begin
         r_gb_valid  <= scram_valid_o;
         r_gb_head   <= !w_half;
         r_gb_data   <= scram_i;
         r_gb_seq    <= w_seq;
         r_underflow <= w_underflow;
      end
   end

   // r_sync is updated on the same edge that raises r_gb_head, so it always
   // belongs to the block whose head is being presented.
   assign gb_valid_o  = r_gb_valid;
   assign gb_head_o   = r_gb_head;
   assign gb_sync_o   = r_gb_head ? r_sync : 2'b00;
   assign gb_data_o   = r_gb_data;
   assign seq_o       = r_gb_seq;
   assign underflow_o = r_underflow;

endmodule : pcs_tx_sched
`default_nettype wire

// File: tb/tb_pcs_tx_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pcs_tx_sched
//  Description : Self-checking bench for pcs_tx_sched. A behavioural model
//                pushes the expected plain word of every scrambler cycle to a
//                queue; a monitor pops and compares against the gearbox
//                output after applying a reference x^58+x^39+1 scrambler.
//                A second instance with an odd period exercises a block that
//                straddles the pause cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pcs_tx_sched;

   localparam int          LEN       = 32;
   localparam logic [5:0]  C_SEQ_MAX = 6'd32;
   localparam logic [57:0] SCR_INIT  = 58'h3FFFFFFFFFFFFFF;

   typedef struct packed {
      logic        head;
      logic [1:0]  sync;
      logic [31:0] plain;
      logic [5:0]  seq;
      logic        uf;
   } exp_t;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           mac_valid_i = 1'b0;
   logic           mac_ctrl_i = 1'b0;
   logic [LEN-1:0] mac_data_i = '0;
   logic           mac_ready_o;
   logic           scram_valid_o;
   logic [LEN-1:0] scram_data_o;
   logic [LEN-1:0] scram_i;
   logic           gb_valid_o;
   logic           gb_head_o;
   logic [1:0]     gb_sync_o;
   logic [LEN-1:0] gb_data_o;
   logic [5:0]     seq_o;
   logic           underflow_o;

   int             n_checks = 0;
   int             n_fail = 0;
   exp_t           q[$];

   logic [5:0]     m_seq = '0;
   logic           m_half = 1'b0;
   logic           m_idle = 1'b0;
   logic [1:0]     m_sync = 2'b00;
   logic [57:0]    m_scr = SCR_INIT;
   logic [31:0]    src = '0;

   always #5 clk = ~clk;

   // Reference scrambler, LSB first; returns {next_state, scrambled_word}.
   function automatic logic [89:0] scr(input logic [31:0] d, input logic [57:0] s);
      logic [57:0] st;
      logic [31:0] o;
      st = s;
      o  = '0;
      for (int i = 0; i < 32; i++) begin
         o[i] = d[i] ^ st[38] ^ st[57];
         st   = {st[56:0], o[i]};
      end
      return {st, o};
   endfunction

   // External scrambler attached to the main instance
   logic [57:0] r_scr_st;
   logic [89:0] w_scr_res;
   assign w_scr_res = scr(scram_data_o, r_scr_st);
   assign scram_i   = w_scr_res[31:0];
   always @(posedge clk) begin
      if (reset) r_scr_st <= SCR_INIT;
      else if (scram_valid_o) r_scr_st <= w_scr_res[89:32];
   end

   pcs_tx_sched #(.LEN(LEN), .SEQ_MAX(32)) u_dut (
      .clk           (clk),
      .reset         (reset),
      .mac_valid_i   (mac_valid_i),
      .mac_ctrl_i    (mac_ctrl_i),
      .mac_data_i    (mac_data_i),
      .mac_ready_o   (mac_ready_o),
      .scram_valid_o (scram_valid_o),
      .scram_data_o  (scram_data_o),
      .scram_i       (scram_i),
      .gb_valid_o    (gb_valid_o),
      .gb_head_o     (gb_head_o),
      .gb_sync_o     (gb_sync_o),
      .gb_data_o     (gb_data_o),
      .seq_o         (seq_o),
      .underflow_o   (underflow_o)
   );

   // Odd-period instance (31 active cycles) so head parity flips each period
   // and a head at the last active seq lands right before the pause.
   logic [15:0]    odd_cnt;
   logic           odd_ready, odd_scr_valid, odd_gb_valid, odd_gb_head, odd_uf;
   logic [LEN-1:0] odd_scr_data, odd_gb_data;
   logic [1:0]     odd_gb_sync;
   logic [5:0]     odd_seq;
   int             span_cnt = 0;
   logic           span_pending = 1'b0;
   logic [31:0]    span_exp = '0;

   always @(posedge clk) begin
      if (reset) odd_cnt <= '0;
      else if (odd_ready) odd_cnt <= odd_cnt + 16'd1;
   end

   pcs_tx_sched #(.LEN(LEN), .SEQ_MAX(31)) u_dut_odd (
      .clk           (clk),
      .reset         (reset),
      .mac_valid_i   (1'b1),
      .mac_ctrl_i    (odd_cnt[1]),
      .mac_data_i    ({16'hC0DE, odd_cnt}),
      .mac_ready_o   (odd_ready),
      .scram_valid_o (odd_scr_valid),
      .scram_data_o  (odd_scr_data),
      .scram_i       (odd_scr_data),
      .gb_valid_o    (odd_gb_valid),
      .gb_head_o     (odd_gb_head),
      .gb_sync_o     (odd_gb_sync),
      .gb_data_o     (odd_gb_data),
      .seq_o         (odd_seq),
      .underflow_o   (odd_uf)
   );

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // One clock of stimulus: drive inputs, step the model, advance to
   // just after the next rising edge.
   task automatic drive_cycle(input logic v, input logic c, input logic [31:0] d,
                              output logic acc);
      exp_t e;
      logic pause;
      logic exp_ready;
      mac_valid_i = v;
      mac_ctrl_i  = c;
      mac_data_i  = d;
      pause     = (m_seq == C_SEQ_MAX);
      exp_ready = !pause && !(m_half && m_idle);
      check_eq("mac_ready", 64'(mac_ready_o), 64'(exp_ready));
      check_eq("scram_valid", 64'(scram_valid_o), 64'(!pause));
      acc = v && exp_ready;
      if (!pause) begin
         if (!m_half) begin
            m_idle  = !v;
            m_sync  = (v && !c) ? 2'b01 : 2'b10;
            e.plain = v ? d : 32'h0000001E;
            e.head  = 1'b1;
            e.sync  = m_sync;
            e.uf    = 1'b0;
         end else begin
            e.plain = (!m_idle && v) ? d : 32'h0;
            e.head  = 1'b0;
            e.sync  = 2'b00;
            e.uf    = !m_idle && !v;
         end
         e.seq = m_seq;
         q.push_back(e);
         m_half = !m_half;
         m_seq  = m_seq + 6'd1;
      end else begin
         m_seq = 6'd0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic v, input logic c);
      logic acc;
      drive_cycle(v, c, 32'hA5000000 + src, acc);
      if (acc) src = src + 32'd1;
   endtask

   task automatic align_head();
      for (int i = 0; i < 4; i++) begin
         if (m_half || m_seq == C_SEQ_MAX) send(1'b1, 1'b0);
      end
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      mac_valid_i = 1'b0;
      mac_ctrl_i  = 1'b0;
      mac_data_i  = '0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      q.delete();
      m_seq  = '0;
      m_half = 1'b0;
      m_idle = 1'b0;
      m_sync = 2'b00;
      m_scr  = SCR_INIT;
      check_eq("rst_gb_valid", 64'(gb_valid_o), 64'(0));
      check_eq("rst_gb_head", 64'(gb_head_o), 64'(0));
      check_eq("rst_gb_sync", 64'(gb_sync_o), 64'(0));
      check_eq("rst_gb_data", 64'(gb_data_o), 64'(0));
      check_eq("rst_seq_o", 64'(seq_o), 64'(0));
      check_eq("rst_underflow", 64'(underflow_o), 64'(0));
      check_eq("rst_mac_ready", 64'(mac_ready_o), 64'(1));
   endtask

   // Main-instance monitor
   initial begin
      exp_t        e;
      logic [89:0] r;
      forever begin
         @(negedge clk);
         if (gb_valid_o) begin
            check_eq("word_expected", 64'(q.size() > 0), 64'(1));
            if (q.size() > 0) begin
               e     = q.pop_front();
               r     = scr(e.plain, m_scr);
               m_scr = r[89:32];
               check_eq("gb_data", 64'(gb_data_o), 64'(r[31:0]));
               check_eq("gb_head", 64'(gb_head_o), 64'(e.head));
               check_eq("gb_sync", 64'(gb_sync_o), 64'(e.sync));
               check_eq("seq_o", 64'(seq_o), 64'(e.seq));
               check_eq("underflow", 64'(underflow_o), 64'(e.uf));
            end
         end else begin
            check_eq("underflow_no_word", 64'(underflow_o), 64'(0));
         end
      end
   end

   // Odd-instance monitor: head at seq 30 is word count 62*j+30 of the
   // current reset epoch; its tail follows the pause at seq 0.
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            span_pending = 1'b0;
            span_cnt     = 0;
         end else if (odd_gb_valid) begin
            check_eq("odd_underflow", 64'(odd_uf), 64'(0));
            if (span_pending) begin
               check_eq("span_tail_seq", 64'(odd_seq), 64'(0));
               check_eq("span_tail_head", 64'(odd_gb_head), 64'(0));
               check_eq("span_tail_data", 64'(odd_gb_data), 64'(span_exp + 32'd1));
               span_pending = 1'b0;
               span_cnt++;
            end else if (odd_gb_head && odd_seq == 6'd30) begin
               span_exp = {16'hC0DE, 16'(62 * span_cnt + 30)};
               check_eq("span_head_data", 64'(odd_gb_data), 64'(span_exp));
               check_eq("span_head_sync", 64'(odd_gb_sync),
                        64'(span_exp[1] ? 2'b10 : 2'b01));
               span_pending = 1'b1;
            end
         end
      end
   end

   initial begin
      @(posedge clk);
      #1;
      do_reset();

      // Idle insertion with no MAC traffic
      repeat (12) send(1'b0, 1'b0);

      // Continuous data across two pause cycles
      repeat (70) send(1'b1, 1'b0);
      check_eq("span_seen", 64'(span_cnt > 0), 64'(1));

      // Mid-block starvation, then a normal block
      align_head();
      send(1'b1, 1'b0);
      send(1'b0, 1'b0);
      send(1'b1, 1'b0);
      send(1'b1, 1'b0);

      // Control head; ctrl on second halves has no effect
      align_head();
      send(1'b1, 1'b1);
      send(1'b1, 1'b1);
      send(1'b1, 1'b0);
      send(1'b1, 1'b1);

      // Idle block while MAC offers data during the idle second half
      align_head();
      send(1'b0, 1'b0);
      send(1'b1, 1'b0);
      send(1'b1, 1'b0);
      send(1'b1, 1'b0);

      // Reset in the second half of the block at seq 17
      do_reset();
      repeat (17) send(1'b1, 1'b0);
      do_reset();
      repeat (10) send(1'b1, 1'b0);
      repeat (4) send(1'b0, 1'b0);

      @(negedge clk);
      #1;
      check_eq("queue_drained", 64'(q.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_pcs_tx_sched
`default_nettype wire
